// File: rtl/tybec_prof_pkg.sv
// Shared types for the TyBEC profiling shell: run-state encoding, report field
// layout and the saturating counter increment.
package tybec_prof_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam int PROFCNTW_DEF = 32;
  localparam int CNT_MAXW     = 64;

  // Field order inside the report beat, LSB field first.
  localparam int RPT_CYC     = 0;
  localparam int RPT_IN      = 1;
  localparam int RPT_OUT     = 2;
  localparam int RPT_STALL   = 3;
  localparam int RPT_NFIELDS = 4;

  function automatic logic [CNT_MAXW-1:0] sat_inc(input logic [CNT_MAXW-1:0] val,
                                                  input int unsigned           width);
    logic [CNT_MAXW-1:0] max_v;
    max_v = (64'd1 << width) - 64'd1;
    if (val >= max_v) begin
      return max_v;
    end else begin
      return val + 64'd1;
    end
  endfunction

endpackage

// File: rtl/tybec_fwft_fifo.sv
// First-word-fall-through FIFO: registered storage, head entry visible one
// cycle after it is written.
module tybec_fwft_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("tybec_fwft_fifo: DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_wr;
  logic             w_rd;

  // The extra pointer bit separates full from empty when the indices match.
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_wr      = i_wr_en & ~o_full;
  assign w_rd      = i_rd_en & ~o_empty;
  assign o_rd_data = r_mem[r_rptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= {(AW+1){1'b0}};
      r_rptr <= {(AW+1){1'b0}};
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end

  // Storage write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= i_wr_data;
    end
  end

endmodule

// File: rtl/func_hdl_prof_shell.sv
// AXI-stream shell around the TyBEC main kernel: input gating to n_items, FWFT
// output buffer, and (with TY_PROF_REPORT_EN) saturating profile counters sent as a trailing report beat.
module func_hdl_prof_shell
  import tybec_prof_pkg::*;
#(
  parameter int NCH_IN      = 4,
  parameter int NCH_OUT     = 4,
  parameter int CHW         = 32,
  parameter int PROFCNTW    = PROFCNTW_DEF,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   start,
  input  logic [31:0]            n_items,
  input  logic                   s_tvalid,
  input  logic [NCH_IN*CHW-1:0]  s_tdata,
  output logic                   s_tready,
  output logic                   k_ivalid,
  output logic [NCH_IN*CHW-1:0]  k_idata,
  input  logic                   k_iready,
  input  logic                   k_ovalid,
  input  logic [NCH_OUT*CHW-1:0] k_odata,
  output logic                   k_oready,
  output logic                   m_tvalid,
  output logic [NCH_OUT*CHW-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic                   busy,
  output logic                   done
);

  localparam int OW = NCH_OUT * CHW;

  generate
    if ((OW < RPT_NFIELDS * PROFCNTW) || (PROFCNTW > CNT_MAXW)) begin : g_bad_report
      $error("func_hdl_prof_shell: output beat too narrow for the profile report");
    end
  endgenerate

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_n_items;
  logic [31:0]     r_in_cnt;
  logic [31:0]     r_out_cnt;
  logic            w_in_ok;
  logic            w_in_hs;
  logic            w_data_vld;
  logic            w_data_hs;
  logic            w_full;
  logic            w_empty;
  logic [OW-1:0]   w_head;

  assign w_in_ok  = (r_state == ST_RUN) && (r_in_cnt < r_n_items);
  assign k_ivalid = s_tvalid & w_in_ok;
  assign s_tready = k_iready & w_in_ok;
  assign k_idata  = s_tdata;
  assign w_in_hs  = s_tvalid & s_tready;
  assign k_oready = ~w_full;
  assign busy     = (r_state != ST_IDLE);

  // Beats beyond out_cnt stay buffered so they can never leak into the report.
  assign w_data_vld = (r_state == ST_RUN) && !w_empty && (r_out_cnt < r_n_items);
  assign w_data_hs  = w_data_vld & m_tready;

  tybec_fwft_fifo #(
    .WIDTH (OW),
    .DEPTH (OFIFO_DEPTH)
  ) u_ofifo (
    .i_clk     (aclk),
    .i_rst_n   (aresetn),
    .i_wr_en   (k_ovalid),
    .i_wr_data (k_odata),
    .i_rd_en   (w_data_hs),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Run control registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= ST_IDLE;
      r_n_items <= 32'd0;
      r_in_cnt  <= 32'd0;
      r_out_cnt <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && start) begin
        r_n_items <= n_items;
        r_in_cnt  <= 32'd0;
        r_out_cnt <= 32'd0;
      end else begin
        if (w_in_hs) begin
          r_in_cnt <= r_in_cnt + 32'd1;
        end
        if (w_data_hs) begin
          r_out_cnt <= r_out_cnt + 32'd1;
        end
      end
    end
  end

`ifdef TY_PROF_REPORT_EN
  logic [PROFCNTW-1:0]    r_prof [RPT_NFIELDS];
  logic [RPT_NFIELDS-1:0] w_prof_inc;
  logic [OW-1:0]          w_report;

  // Per-counter increment enables, only meaningful while running
  always_comb begin
    w_prof_inc            = {RPT_NFIELDS{1'b0}};
    w_prof_inc[RPT_CYC]   = (r_state == ST_RUN);
    w_prof_inc[RPT_IN]    = w_in_hs;
    w_prof_inc[RPT_OUT]   = w_data_hs;
    w_prof_inc[RPT_STALL] = w_data_vld & ~m_tready;
  end

  // Saturating profile counters: cleared on start, hold outside RUN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < RPT_NFIELDS; i++) begin
        r_prof[i] <= {PROFCNTW{1'b0}};
      end
    end else if ((r_state == ST_IDLE) && start) begin
      for (int i = 0; i < RPT_NFIELDS; i++) begin
        r_prof[i] <= {PROFCNTW{1'b0}};
      end
    end else begin
      for (int i = 0; i < RPT_NFIELDS; i++) begin
        if (w_prof_inc[i]) begin
          r_prof[i] <= PROFCNTW'(sat_inc(CNT_MAXW'(r_prof[i]), PROFCNTW));
        end
      end
    end
  end

  // Report word assembly
  always_comb begin
    w_report = {OW{1'b0}};
    for (int i = 0; i < RPT_NFIELDS; i++) begin
      w_report[i*PROFCNTW +: PROFCNTW] = r_prof[i];
    end
  end

  // Next state and stream outputs
  always_comb begin
    w_state_nxt = r_state;
    m_tvalid    = w_data_vld;
    m_tlast     = 1'b0;
    m_tdata     = w_data_vld ? w_head : {OW{1'b0}};
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (n_items == 32'd0) ? ST_REPORT : ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_out_cnt == r_n_items) begin
          w_state_nxt = ST_REPORT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_REPORT: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tdata  = w_report;
        done     = m_tready;
        if (m_tready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_REPORT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end
`else
  logic w_is_last;

  assign w_is_last = (r_out_cnt == (r_n_items - 32'd1));

  // Next state and stream outputs; the last data beat closes the run
  always_comb begin
    w_state_nxt = r_state;
    m_tvalid    = w_data_vld;
    m_tlast     = w_data_vld & w_is_last;
    m_tdata     = w_data_vld ? w_head : {OW{1'b0}};
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && (n_items != 32'd0)) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
        done = start & (n_items == 32'd0);
      end
      ST_RUN: begin
        if (w_data_hs && w_is_last) begin
          w_state_nxt = ST_IDLE;
          done        = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end
`endif

endmodule
